// File: rtl/fifo_rd_pkg.sv
// Shared types and widths for the FIFO read-side unpacker.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fifo_rd_pkg;

  localparam int FIFO_W = 128;
  localparam int BEAT_W = 32;

  typedef logic [FIFO_W-1:0] fifo_word_t;
  typedef logic [BEAT_W-1:0] beat_t;

  // Encoding doubles as the buffer occupancy count.
  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fifo_rd_unpacker_if.sv
// Bundle of FIFO read-side and beat-stream signals for the unpacker.
// Latency: n/a (wiring only).
// Backpressure: m_ready from the sink; the FIFO side is paced by o_rden.
// master = unpacker side, slave = FIFO + sink side.
interface fifo_rd_unpacker_if #(
  parameter int IN_W  = fifo_rd_pkg::FIFO_W,
  parameter int OUT_W = fifo_rd_pkg::BEAT_W
);
  logic             o_rden;
  logic [IN_W-1:0]  i_rddata;
  logic             i_empty;
  logic             i_alm_empty;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic             m_last;
  logic [15:0]      o_words;

  modport master (
    output o_rden,
    input  i_rddata, i_empty, i_alm_empty,
    output m_valid,
    input  m_ready,
    output m_data, m_last, o_words
  );

  modport slave (
    input  o_rden,
    output i_rddata, i_empty, i_alm_empty,
    input  m_valid,
    output m_ready,
    input  m_data, m_last, o_words
  );
endinterface

// File: rtl/fifo_rd_wordbuf.sv
// Two-entry word buffer: captures FIFO read data, retires the head word on request.
// Latency: captured word becomes head (or next) on the capture edge.
// Backpressure: none internally; the issuer never captures while two words are held.
// Ports: cap_vld/cap_dat capture input, retire_vld head retire, occ occupancy, head_dat head word.
module fifo_rd_wordbuf
  import fifo_rd_pkg::*;
#(
  parameter int W = FIFO_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cap_vld,
  input  logic [W-1:0] cap_dat,
  input  logic         retire_vld,
  output logic [1:0]   occ,
  output logic [W-1:0] head_dat
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] next_q, next_d;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    next_d  = next_q;
    case (state_q)
      B0: begin
        if (cap_vld) begin
          head_d  = cap_dat;
          state_d = B1;
        end
      end
      B1: begin
        case ({cap_vld, retire_vld})
          2'b10: begin
            next_d  = cap_dat;
            state_d = B2;
          end
          2'b01: state_d = B0;
          // Retiring head while a new word lands: the new word is the head.
          2'b11: head_d = cap_dat;
          default: ;
        endcase
      end
      B2: begin
        if (retire_vld) begin
          head_d  = next_q;
          state_d = B1;
        end
      end
      default: state_d = B0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= B0;
      head_q  <= '0;
      next_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      next_q  <= next_d;
    end
  end

  assign occ      = state_q;
  assign head_dat = head_q;

endmodule

// File: rtl/fifo_rd_unpacker.sv
// Reads 128-bit words from a sync FIFO and emits them as 32-bit valid/ready beats.
// Latency: o_rden -> pop at edge k, capture at k+1, first beat valid the cycle after; 1 beat/cycle sustained.
// Backpressure: m_ready low holds the beat; FIFO reads stop once two words are held or in flight.
// Ports: clk, rstn, bus (master: o_rden/i_rddata/i_empty/i_alm_empty, m_valid/m_ready/m_data/m_last, o_words).
// Option: define FIFO_RD_UNPK_BE_EN to emit beats from the top of the word down.
module fifo_rd_unpacker
  import fifo_rd_pkg::*;
#(
  parameter int IN_W  = FIFO_W,
  parameter int OUT_W = BEAT_W
) (
  input  logic                clk,
  input  logic                rstn,
  fifo_rd_unpacker_if.master  bus
);

  localparam int BEATS = IN_W / OUT_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic            rden_q, rden_d;
  logic            inflight_q, inflight_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [15:0]     words_q, words_d;
  logic [1:0]      occ;
  logic [IN_W-1:0] head;
  logic            xfer;
  logic            retire_vld;
  logic [2:0]      reserved;

  assign xfer       = bus.m_valid && bus.m_ready;
  assign retire_vld = xfer && (beat_q == LAST_BEAT);
  // Words held + word in flight + pop happening at this edge; occupancy is
  // taken before any retire so the buffer can never be over-committed.
  assign reserved   = {1'b0, occ} + {2'b0, inflight_q} + {2'b0, rden_q};

  always_comb begin
    rden_d     = 1'b0;
    inflight_d = rden_q;
    beat_d     = beat_q;
    words_d    = words_q;
    if (reserved < 3'd2 && !bus.i_empty) begin
      // Back-to-back reads only when at least two words are known stored,
      // since i_empty does not yet reflect the pop at this edge.
      rden_d = rden_q ? !bus.i_alm_empty : 1'b1;
    end
    if (xfer) begin
      if (beat_q == LAST_BEAT) begin
        beat_d  = '0;
        words_d = words_q + 16'd1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rden_q     <= 1'b0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      words_q    <= '0;
    end else begin
      rden_q     <= rden_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      words_q    <= words_d;
    end
  end

  fifo_rd_wordbuf #(.W(IN_W)) u_wordbuf (
    .clk        (clk),
    .rstn       (rstn),
    .cap_vld    (inflight_q),
    .cap_dat    (bus.i_rddata),
    .retire_vld (retire_vld),
    .occ        (occ),
    .head_dat   (head)
  );

  assign bus.o_rden  = rden_q;
  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_last  = (beat_q == LAST_BEAT);
  assign bus.o_words = words_q;
`ifdef FIFO_RD_UNPK_BE_EN
  assign bus.m_data  = head[IN_W - 1 - int'(beat_q) * OUT_W -: OUT_W];
`else
  assign bus.m_data  = head[int'(beat_q) * OUT_W +: OUT_W];
`endif

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
`timescale 1ns/1ps
module tb_fifo_rd_unpacker;
  import fifo_rd_pkg::*;

  typedef struct packed {
    beat_t dat;
    logic  last;
  } exp_t;

  localparam fifo_word_t W_SINGLE = 128'h44444444_33333333_22222222_11111111;
`ifdef FIFO_RD_UNPK_BE_EN
  localparam beat_t FIRST_EXP = 32'h44444444;
  localparam beat_t LAST_EXP  = 32'h11111111;
`else
  localparam beat_t FIRST_EXP = 32'h11111111;
  localparam beat_t LAST_EXP  = 32'h44444444;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int checks   = 0;
  int failures = 0;

  fifo_word_t fifo_q[$];
  exp_t       exp_q[$];
  logic       rden_s = 1'b0;
  bit         bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int         bp_idx = 0;

  int    beats_seen = 0;
  int    last_cnt = 0;
  int    rden_pulses = 0;
  int    rden_b2b = 0;
  logic  rden_prev = 1'b0;
  beat_t first_dat = '0;
  beat_t last_dat = '0;
  logic  stall_prev = 1'b0;
  beat_t held_dat = '0;
  logic  held_last = 1'b0;
  exp_t  mon_e;

  fifo_rd_unpacker_if #(.IN_W(FIFO_W), .OUT_W(BEAT_W)) bus ();

  fifo_rd_unpacker #(.IN_W(FIFO_W), .OUT_W(BEAT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // FIFO model with registered read data, plus sink ready pattern.
  initial begin
    bus.i_rddata    = '0;
    bus.i_empty     = 1'b1;
    bus.i_alm_empty = 1'b1;
    bus.m_ready     = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rden_s && fifo_q.size() > 0) bus.i_rddata = fifo_q.pop_front();
      bus.i_empty     = (fifo_q.size() == 0);
      bus.i_alm_empty = (fifo_q.size() < 2);
      bus.m_ready     = bp_en ? bp_pat[bp_idx % 4] : 1'b1;
      if (bp_en) bp_idx++;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    rden_s = bus.o_rden;
    if (!rstn) begin
      stall_prev = 1'b0;
      rden_prev  = 1'b0;
    end else begin
      if (bus.o_rden) begin
        rden_pulses++;
        if (rden_prev) rden_b2b++;
        checks++;
        if (fifo_q.size() == 0) begin
          failures++;
          $display("FAIL read_past_empty o_rden=1 fifo_words=0 required>0 t=%0t", $time);
        end
      end
      rden_prev = bus.o_rden;
      if (dut.u_wordbuf.cap_vld) begin
        checks++;
        if (dut.u_wordbuf.state_q == B2) begin
          failures++;
          $display("FAIL capture_in_b2 state=B2 required=B0/B1 t=%0t", $time);
        end
      end
      if (stall_prev) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== held_dat || bus.m_last !== held_last) begin
          failures++;
          $display("FAIL stall_stable got=%b/%h/%b required=1/%h/%b t=%0t",
                   bus.m_valid, bus.m_data, bus.m_last, held_dat, held_last, $time);
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected got=%h last=%b required=no_beat t=%0t", bus.m_data, bus.m_last, $time);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.m_data !== mon_e.dat || bus.m_last !== mon_e.last) begin
            failures++;
            $display("FAIL beat_data got=%h last=%b required=%h last=%b t=%0t",
                     bus.m_data, bus.m_last, mon_e.dat, mon_e.last, $time);
          end
        end
        if (beats_seen == 0) first_dat = bus.m_data;
        if (bus.m_last) begin
          last_dat = bus.m_data;
          last_cnt++;
        end
        beats_seen++;
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      held_dat   = bus.m_data;
      held_last  = bus.m_last;
    end
  end

  task automatic push_word(input fifo_word_t w);
    exp_t e;
    fifo_q.push_back(w);
    for (int b = 0; b < 4; b++) begin
`ifdef FIFO_RD_UNPK_BE_EN
      e.dat = w[FIFO_W - 1 - b * BEAT_W -: BEAT_W];
`else
      e.dat = w[b * BEAT_W +: BEAT_W];
`endif
      e.last = (b == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !bus.m_valid && !bus.o_rden) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn  = 1'b0;
    bp_en = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    beats_seen  = 0;
    last_cnt    = 0;
    rden_pulses = 0;
    rden_b2b    = 0;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    bit ok;
    @(negedge clk);
    rstn = 1'b0;
    push_word(W_SINGLE);
    repeat (3) @(negedge clk);
    checks++; if (bus.o_rden !== 1'b0) begin failures++; $display("FAIL reset_rden got=%b required=0", bus.o_rden); end
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b required=0", bus.m_valid); end
    checks++; if (bus.o_words !== 16'd0) begin failures++; $display("FAIL reset_words got=%h required=0", bus.o_words); end
    checks++; if (bus.m_data !== 32'd0 || bus.m_last !== 1'b0) begin
      failures++; $display("FAIL reset_data got=%h/%b required=0/0", bus.m_data, bus.m_last);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (bus.o_rden !== 1'b1) begin failures++; $display("FAIL first_rden got=%b required=1", bus.o_rden); end
    @(negedge clk);
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL valid_early got=%b required=0", bus.m_valid); end
    @(negedge clk);
    checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL valid_latency got=%b required=1", bus.m_valid); end
    wait_idle(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL reset_drain got=busy required=idle"); end
  endtask

  task automatic test_single_word();
    bit ok;
    do_reset();
    push_word(W_SINGLE);
    wait_idle(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_drain got=busy required=idle"); end
    checks++; if (bus.o_words !== 16'd1) begin failures++; $display("FAIL single_words got=%0d required=1", bus.o_words); end
    checks++; if (rden_pulses != 1) begin failures++; $display("FAIL single_rden got=%0d required=1", rden_pulses); end
    checks++; if (beats_seen != 4 || last_cnt != 1) begin
      failures++; $display("FAIL single_beats got=%0d/%0d required=4/1", beats_seen, last_cnt);
    end
    checks++; if (first_dat !== FIRST_EXP) begin failures++; $display("FAIL single_first got=%h required=%h", first_dat, FIRST_EXP); end
    checks++; if (last_dat !== LAST_EXP) begin failures++; $display("FAIL single_last got=%h required=%h", last_dat, LAST_EXP); end
  endtask

  task automatic test_streaming();
    bit ok;
    int nvalid;
    do_reset();
    for (int i = 0; i < 8; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 20 && !bus.m_valid; i++) @(negedge clk);
    checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL stream_start got=%b required=1", bus.m_valid); end
    nvalid = 0;
    for (int i = 0; i < 32; i++) begin
      if (bus.m_valid === 1'b1) nvalid++;
      @(negedge clk);
    end
    checks++; if (nvalid != 32) begin failures++; $display("FAIL stream_bubble got=%0d required=32", nvalid); end
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL stream_end got=%b required=0", bus.m_valid); end
    wait_idle(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stream_drain got=busy required=idle"); end
    checks++; if (bus.o_words !== 16'd8) begin failures++; $display("FAIL stream_words got=%0d required=8", bus.o_words); end
    checks++; if (rden_pulses != 8) begin failures++; $display("FAIL stream_rden got=%0d required=8", rden_pulses); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    bp_idx = 0;
    bp_en  = 1'b1;
    for (int i = 0; i < 5; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    wait_idle(300, ok);
    bp_en = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL bp_drain got=busy required=idle"); end
    checks++; if (beats_seen != 20) begin failures++; $display("FAIL bp_beats got=%0d required=20", beats_seen); end
    checks++; if (bus.o_words !== 16'd5) begin failures++; $display("FAIL bp_words got=%0d required=5", bus.o_words); end
  endtask

  task automatic test_empty_edge();
    bit ok;
    int n;
    do_reset();
    repeat (3) @(negedge clk);
    push_word({$urandom, $urandom, $urandom, $urandom});
    n = 0;
    while (!bus.m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.m_valid !== 1'b1 || n < 3) begin
      failures++; $display("FAIL empty_latency got=%0d cycles valid=%b required>=3 valid=1", n, bus.m_valid);
    end
    wait_idle(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL empty_drain got=busy required=idle"); end
    checks++; if (rden_pulses != 1 || rden_b2b != 0) begin
      failures++; $display("FAIL empty_rden got=%0d/%0d required=1/0", rden_pulses, rden_b2b);
    end
  endtask

  task automatic test_words_wrap();
    bit ok;
    do_reset();
    @(negedge clk);
    force dut.words_q = 16'hFFFF;
    @(negedge clk);
    release dut.words_q;
    @(negedge clk);
    checks++; if (bus.o_words !== 16'hFFFF) begin failures++; $display("FAIL wrap_preset got=%h required=ffff", bus.o_words); end
    push_word(W_SINGLE);
    wait_idle(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_drain got=busy required=idle"); end
    checks++; if (bus.o_words !== 16'h0000) begin failures++; $display("FAIL wrap_words got=%h required=0000", bus.o_words); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_empty_edge();
    test_words_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_unpacker.md
Name: fifo_rd_unpacker

Overview:
- Downstream consumer of the 128-bit sync FIFO read side.
- Issues i_rden to the FIFO and absorbs the 1-cycle read latency in a 2-entry word buffer.
- Unpacks each 128-bit word into four 32-bit beats on a valid/ready stream for the next pipeline stage.
- Sustains 1 beat/cycle when the FIFO is non-empty and the sink is always ready.

Parameters:
- IN_W, 128, FIFO word width; must be an integer multiple of OUT_W.
- OUT_W, 32, output beat width.
- BEATS, IN_W/OUT_W (=4), beats per word; derived localparam, not overridable.

Ports:
- clk  input  1  clock; all state on posedge.
- rstn  input  1  asynchronous active-low reset.
- o_rden  output  1  FIFO read enable, registered.
- i_rddata  input  IN_W  FIFO read data; valid the cycle after o_rden is sampled.
- i_empty  input  1  FIFO empty.
- i_alm_empty  input  1  FIFO almost-empty; 0 guarantees at least 2 words stored.
- m_valid  output  1  output beat valid.
- m_ready  input  1  sink ready.
- m_data  output  OUT_W  output beat.
- m_last  output  1  high on the final beat (BEATS-1) of each word.
- o_words  output  16  count of fully consumed words; wraps at 0xFFFF -> 0.

Behaviour:
- Reset values, asserted asynchronously: o_rden=0, m_valid=0, m_data=0, m_last=0, o_words=0, beat index=0, buffer occupancy=0, in-flight flag=0.
- Read latency:
  - o_rden high at edge k means the FIFO pops at edge k.
  - i_rddata is captured into the buffer at edge k+1, setting in-flight=1 between those edges.
- Issue rule, evaluated at each edge to set o_rden for the next cycle:
  - Condition: (occupancy + inflight + next-o_rden-pending) < 2 AND i_empty==0.
  - If o_rden is already 1 this cycle, it may stay 1 only when i_alm_empty==0. Otherwise one idle cycle is forced, so a read past the last word is never issued.
- Buffer FSM (states by occupancy):
  - B0: no word held.
  - B1: head word held.
  - B2: head + next word held.
  - B0->B1 on capture.
  - B1->B2 on capture without head retire.
  - B1->B0 on head retire without capture.
  - B2->B1 on head retire.
  - Capture and retire in the same cycle keep the state unchanged.
  - Capture in B2 cannot occur; the issue rule prevents it. A bench assertion checks this.
- Output:
  - m_valid = (occupancy != 0).
  - m_data = head[beat*OUT_W +: OUT_W], beat 0 = bits [31:0].
  - m_last = (beat == BEATS-1).
  - m_data/m_last are combinational from registered state.
- Handshake:
  - A beat transfers when m_valid && m_ready.
  - On transfer: beat increments. At BEATS-1, beat wraps to 0, the head retires, the next word (if any) becomes head in the same edge, and o_words increments.
  - m_data stays stable while m_valid && !m_ready.
- Throughput: with m_ready=1 and ≥2 words in the FIFO, m_valid stays high continuously, with no bubble at word boundaries.
- FIFO empty: m_valid drops after the last beat of the last buffered word. The next word appears ≥2 cycles after i_empty falls (issue + capture).
- Reset mid-operation: buffer contents and beat index are discarded immediately. A read in flight at reset is lost; the system-level reset of the FIFO covers this.

Optional Feature:
- Macro: FIFO_RD_UNPK_BE_EN.
- Defined: beat order reversed, beat 0 = head[IN_W-1 -: OUT_W] (bits [127:96]); m_last still marks the 4th beat.
- Undefined: little-endian order as above.
- No other behaviour changes.

Decomposition:
- Package fifo_rd_pkg holds:
  - localparams FIFO_W=128 and BEAT_W=32.
  - typedef fifo_word_t (logic [FIFO_W-1:0]).
  - typedef beat_t.
  - enum buf_state_e {B0,B1,B2}.
- One sub-module, fifo_rd_wordbuf: the 2-entry capture/retire buffer with occupancy FSM.
- The top level holds the issue logic, beat counter, mux and word counter.

Test Plan:
- Reset: hold rstn=0 with i_empty=0. Expect o_rden=0, m_valid=0, o_words=0. Deassert rstn: first o_rden within 1 cycle, m_valid 2 cycles later.
- Single word: FIFO holds 0x44444444_33333333_22222222_11111111, m_ready=1. Expect beats 0x11111111, 0x22222222, 0x33333333, 0x44444444, m_last on the 4th, o_words=1, exactly one o_rden pulse.
- Streaming: 8 words preloaded, m_ready=1. Expect 32 consecutive valid beats with no bubble, o_words=8, and no o_rden while i_empty=1.
- Backpressure: m_ready toggles 1,0,0,1 repeatedly. Expect m_data/m_last stable during stalls, no beat lost or duplicated, occupancy never exceeding 2.
- Empty edge: FIFO holds 1 word (i_alm_empty=1). Expect no back-to-back o_rden and no read while i_empty=1.
- With FIFO_RD_UNPK_BE_EN defined: the single-word test yields 0x44444444 first and 0x11111111 last with m_last. o_words wrap: force 0xFFFF plus one word gives 0.
